// File: rtl/booth_seq_if.sv
// Operand/product bundle for the registered Booth multiplier.
interface booth_seq_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [63:0] result;

  modport master (output A, output B, input result);
  modport slave  (input A, input B, output result);
endinterface

// File: rtl/booth_seq.sv
// Signed 32x32 radix-2 Booth multiplier: 32 unrolled combinational steps
// feeding a single output register.

// One Booth step on P = {U[32:0], L[31:0], q}: add/sub M on {L[0], q}, then
// arithmetic shift right by one.
module booth_stage (
  input  logic [65:0] p_in,
  input  logic [32:0] m,
  output logic [65:0] p_out
);
  logic [32:0] u;

  always_comb begin
    u = p_in[65:33];
    case (p_in[1:0])
      2'b01:   u = p_in[65:33] + m;
      2'b10:   u = p_in[65:33] - m;
      default: u = p_in[65:33];
    endcase
    p_out = {u[32], u, p_in[32:1]};
  end
endmodule

module booth_seq (
  input  logic        clk,
  input  logic        reset,
  booth_seq_if.slave  io
);
  localparam int STEPS = 32;

  // 33-bit multiplicand keeps U from overflowing when A = -2^31.
  logic [32:0] m;
  logic [63:0] prod;

  assign m = {io.A[31], io.A};

  for (genvar g = 0; g < STEPS; g++) begin : stg
    logic [65:0] p_in;
    logic [65:0] p_out;
    if (g == 0) begin : g_first
      assign p_in = {33'd0, io.B, 1'b0};
    end else begin : g_chain
      assign p_in = stg[g-1].p_out;
    end
    booth_stage u_stage (.p_in(p_in), .m(m), .p_out(p_out));
  end

  assign prod = stg[STEPS-1].p_out[64:1];

  always_ff @(posedge clk) begin
    if (reset) io.result <= '0;
    else       io.result <= prod;
  end
endmodule

// File: tb/tb_booth_seq.sv
// Scoreboard bench for booth_seq: driver queues expected products, monitor
// checks one cycle later.
module tb_booth_seq;
  logic clk;
  logic reset;
  booth_seq_if bif ();

  booth_seq dut (.clk(clk), .reset(reset), .io(bif.slave));

  typedef struct {
    logic [63:0] exp;
    string       name;
  } ent_t;

  ent_t sb[$];
  int checks = 0;
  int failures = 0;
  bit done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operand pair ahead of the next rising edge and queue the
  // value the register must hold right after that edge.
  task automatic step(input logic [31:0] a, input logic [31:0] b,
                      input logic rst, input logic [63:0] exp,
                      input string name);
    ent_t e;
    @(negedge clk);
    bif.A = a;
    bif.B = b;
    reset = rst;
    e.exp = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      ent_t e;
      e = sb.pop_front();
      checks++;
      if (bif.result !== e.exp) begin
        failures++;
        $display("FAIL %s: result=%h expected=%h", e.name, bif.result, e.exp);
      end
    end
  end

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] rexp;
    bif.A = '0;
    bif.B = '0;
    reset = 1'b1;

    step(32'd7, 32'd9, 1'b1, 64'd0, "reset0");
    step(32'd7, 32'd9, 1'b1, 64'd0, "reset1");
    step(32'd7, 32'd9, 1'b0, 64'd63, "release");

    step(32'd50, -32'sd40, 1'b0, 64'hFFFF_FFFF_FFFF_F830, "50x-40");
    step(32'd90, 32'd70, 1'b0, 64'd6300, "90x70");
    step(-32'sd80, -32'sd65, 1'b0, 64'd5200, "-80x-65");
    step(-32'sd10, 32'd325, 1'b0, -64'sd3250, "-10x325");
    step(32'd98756, 32'd0, 1'b0, 64'd0, "x0");
    step(32'd98765, 32'd1, 1'b0, 64'd98765, "x1");
    step(-32'sd500, 32'd2000, 1'b0, -64'sd1000000, "-500x2000");
    step(-32'sd999, 32'd999, 1'b0, -64'sd998001, "-999x999");
    step(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, "min_x_min");
    step(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 64'hC000_0000_8000_0000, "min_x_max");
    step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'd1, "-1x-1");
    step(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 64'h3FFF_FFFF_0000_0001, "max_x_max");
    step(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 64'h0000_0000_8000_0000, "min_x_-1");

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom();
      rb = $urandom();
      rexp = 64'($signed(ra)) * 64'($signed(rb));
      if (i == 500 || i == 501)
        step(ra, rb, 1'b1, 64'd0, "sweep_reset");
      else
        step(ra, rb, 1'b0, rexp, "sweep");
    end

    step(32'd3, -32'sd4, 1'b0, -64'sd12, "post_sweep");
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d expected=0", sb.size());
    end
    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: done=0 expected=1");
      $fatal(1, "timeout");
    end
  end
endmodule
